// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the Jump/Add/Li instruction fetch unit:
// opcode fields, special instruction words and fetch state encoding.
package inst_fetch_unit_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LI   = 2'b01;
  localparam logic [1:0] OP_MISC = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  localparam logic [7:0] INS_NOP  = 8'h80;
  localparam logic [7:0] INS_HALT = 8'hBF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Control, program-load and instruction-issue signals of the fetch unit.
// master: the fetch unit itself; slave: the decoder / host side.
interface inst_fetch_unit_if #(
  parameter int unsigned PC_W  = 4,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stall;
  logic             prog_we;
  logic [PC_W-1:0]  prog_addr;
  logic [7:0]       prog_data;
  logic             pc_src;
  logic [7:0]       ins_code;
  logic             ins_valid;
  logic [PC_W-1:0]  ins_pc;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, stall, prog_we, prog_addr, prog_data, pc_src,
    output ins_code, ins_valid, ins_pc, busy, halted, instr_count
  );

  modport slave (
    output start, stall, prog_we, prog_addr, prog_data, pc_src,
    input  ins_code, ins_valid, ins_pc, busy, halted, instr_count
  );
endinterface

// File: rtl/inst_fetch_unit_inst_mem.sv
// Writable instruction store: synchronous write, combinational read.
// Contents are deliberately not reset so a loaded program survives reset.
module inst_mem #(
  parameter int unsigned PC_W = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [7:0]      rdata
);
  logic [7:0] mem [2**PC_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, loadable imem, start/halt run control,
// stall hold and saturating issued-instruction counter.
import inst_fetch_unit_pkg::*;

module inst_fetch_unit #(
  parameter int unsigned PC_W  = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  inst_fetch_unit_if.master bus
);
  fetch_state_t     state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  next_addr, rd_addr;
  logic [7:0]       rd_data;
  logic             mem_we;

  inst_mem #(.PC_W(PC_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= INS_NOP;
      valid_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    next_addr = (bus.pc_src && valid_q) ? code_q[PC_W-1:0] : pc_q + PC_W'(1);
    // Outside RUN the only read needed is address 0 for start; the read sees
    // the pre-write contents, so a same-cycle write to 0 is not picked up.
    rd_addr   = (state_q == ST_RUN) ? next_addr : '0;
    state_d   = state_q;
    code_d    = code_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        mem_we = bus.prog_we;
        if (bus.start) begin
          state_d = ST_RUN;
          code_d  = rd_data;
          valid_d = 1'b1;
          pc_d    = '0;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (code_q == INS_HALT) begin
            state_d = ST_HALTED;
            code_d  = INS_NOP;
            valid_d = 1'b0;
          end else begin
            code_d = rd_data;
            pc_d   = next_addr;
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ins_code    = code_q;
  assign bus.ins_valid   = valid_q;
  assign bus.ins_pc      = pc_q;
  assign bus.instr_count = cnt_q;
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.halted      = (state_q == ST_HALTED);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit (PC_W=4, CNT_W=16).
module tb_inst_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  inst_fetch_unit_if #(.PC_W(4), .CNT_W(16)) bus ();

  inst_fetch_unit #(.PC_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: jump opcode on a live instruction is always taken.
  assign bus.pc_src = bus.ins_valid && (bus.ins_code[7:6] == 2'b11);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    step();
    bus.prog_we   = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) load(4'(i), 8'h80);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic expect_ins(input string tag, input logic [7:0] code,
                            input logic [3:0] pc, input logic [15:0] cnt);
    check({tag, ".code"},  32'(bus.ins_code), 32'(code));
    check({tag, ".pc"},    32'(bus.ins_pc), 32'(pc));
    check({tag, ".cnt"},   32'(bus.instr_count), 32'(cnt));
    check({tag, ".valid"}, 32'(bus.ins_valid), 32'd1);
  endtask

  task automatic expect_halt(input string tag, input logic [15:0] cnt);
    check({tag, ".valid"},  32'(bus.ins_valid), 32'd0);
    check({tag, ".code"},   32'(bus.ins_code), 32'h80);
    check({tag, ".halted"}, 32'(bus.halted), 32'd1);
    check({tag, ".busy"},   32'(bus.busy), 32'd0);
    check({tag, ".cnt"},    32'(bus.instr_count), 32'(cnt));
  endtask

  task automatic expect_reset(input string tag);
    check({tag, ".code"},   32'(bus.ins_code), 32'h80);
    check({tag, ".valid"},  32'(bus.ins_valid), 32'd0);
    check({tag, ".pc"},     32'(bus.ins_pc), 32'd0);
    check({tag, ".busy"},   32'(bus.busy), 32'd0);
    check({tag, ".halted"}, 32'(bus.halted), 32'd0);
    check({tag, ".cnt"},    32'(bus.instr_count), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    step();
    step();
    expect_reset("rst");
    reset = 1'b0;
    step();
    expect_reset("idle");

    // Straight line
    fill_nop();
    load(4'd0, 8'h41);
    load(4'd1, 8'h02);
    load(4'd2, 8'hBF);
    pulse_start();
    expect_ins("sl0", 8'h41, 4'd0, 16'd1);
    check("sl0.busy", 32'(bus.busy), 32'd1);
    step();
    expect_ins("sl1", 8'h02, 4'd1, 16'd2);
    step();
    expect_ins("sl2", 8'hBF, 4'd2, 16'd3);
    step();
    expect_halt("sl_h", 16'd3);
    check("sl_h.pc", 32'(bus.ins_pc), 32'd2);

    // Stall during the same program, HALT delayed by stall
    pulse_start();
    step();
    expect_ins("st1", 8'h02, 4'd1, 16'd2);
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      expect_ins("st_hold", 8'h02, 4'd1, 16'd2);
    end
    bus.stall = 1'b0;
    step();
    expect_ins("st2", 8'hBF, 4'd2, 16'd3);
    bus.stall = 1'b1;
    step();
    expect_ins("st_halt_hold", 8'hBF, 4'd2, 16'd3);
    bus.stall = 1'b0;
    step();
    expect_halt("st_h", 16'd3);

    // Jump without bubble
    load(4'd0, 8'hC3);
    load(4'd1, 8'h01);
    load(4'd3, 8'hBF);
    pulse_start();
    expect_ins("j0", 8'hC3, 4'd0, 16'd1);
    step();
    expect_ins("j1", 8'hBF, 4'd3, 16'd2);
    step();
    expect_halt("j_h", 16'd2);

    // Short wrap program: halt at address 1
    fill_nop();
    load(4'd1, 8'hBF);
    pulse_start();
    expect_ins("w0", 8'h80, 4'd0, 16'd1);
    step();
    expect_ins("w1", 8'hBF, 4'd1, 16'd2);
    step();
    expect_halt("w_h", 16'd2);

    // All NOPs: PC wraps 15 -> 0
    load(4'd1, 8'h80);
    pulse_start();
    for (int i = 0; i < 15; i++) step();
    expect_ins("wr15", 8'h80, 4'd15, 16'd16);
    step();
    expect_ins("wr0", 8'h80, 4'd0, 16'd17);

    // Reset mid-run stops the NOP loop; then reset at ins_pc=2
    #1 reset = 1'b1;
    #2 expect_reset("rst_nop");
    reset = 1'b0;
    load(4'd0, 8'h41);
    load(4'd1, 8'h02);
    load(4'd2, 8'h03);
    load(4'd3, 8'hBF);
    pulse_start();
    step();
    step();
    expect_ins("rm2", 8'h03, 4'd2, 16'd3);
    #1 reset = 1'b1;
    #2 expect_reset("rm_async");
    step();
    reset = 1'b0;
    pulse_start();
    expect_ins("rp0", 8'h41, 4'd0, 16'd1);
    step();
    expect_ins("rp1", 8'h02, 4'd1, 16'd2);

    // Ignored controls in RUN: prog_we and start
    bus.prog_we = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = 8'hFF;
    bus.start = 1'b1;
    step();
    bus.prog_we = 1'b0;
    bus.start = 1'b0;
    expect_ins("ig2", 8'h03, 4'd2, 16'd3);
    step();
    expect_ins("ig3", 8'hBF, 4'd3, 16'd4);
    step();
    expect_halt("ig_h", 16'd4);
    pulse_start();
    expect_ins("ig_mem0", 8'h41, 4'd0, 16'd1);
    check("ig_halted_clr", 32'(bus.halted), 32'd0);
    for (int i = 0; i < 4; i++) step();
    expect_halt("ig_h2", 16'd4);

    // Same-cycle prog_we and start: start sees the old word
    bus.prog_we = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = 8'h55;
    bus.start = 1'b1;
    step();
    bus.prog_we = 1'b0;
    bus.start = 1'b0;
    expect_ins("ws_old", 8'h41, 4'd0, 16'd1);
    for (int i = 0; i < 4; i++) step();
    expect_halt("ws_h", 16'd4);
    pulse_start();
    expect_ins("ws_new", 8'h55, 4'd0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
